reset_tick_sequencer: RTL
=========================

// Module: reset_tick_sequencer
// PURPOSE
// - Generalised board-level reset/timebase block for the ice40 top level.
// - Divides the board clock into a 1-cycle tick pulse and a square wave (the 100 Hz timebase).
// - Sequences the design reset from that tick: power-on hold plus a debounced manual button-combo reset.
// - Drives the reset into top; tick/sq_wave are available to game logic.
// PARAMETERS
// - TICK_DIV        100000  clk cycles per tick (>=2); 10 MHz / 100000 = 100 Hz tick
// - HOLD_TICKS      4       ticks rst_out is held high after PRE (>=1)
// - NUM_BTN         3       number of buttons forming the manual-reset combo (>=1)
// - DEBOUNCE_TICKS  2       consecutive ticks the combo must be held before a manual reset (>=1)
// - SYNC_STAGES     2       synchroniser flops per button (>=2)
// PORTS
// - clk          in   1        design clock (hwclk)
// - nrst         in   1        asynchronous, active-low reset
// - btn          in   NUM_BTN  raw async push-button inputs; combo = AND of all bits
// - tick         out  1        1-cycle pulse every TICK_DIV cycles
// - sq_wave      out  1        toggles on every tick (period 2*TICK_DIV)
// - rst_out      out  1        active-high design reset to top
// - state        out  2        0=PRE 1=HOLD 2=RUN 3=MANUAL
// - manual_cnt   out  8        number of manual resets taken, saturates at 255
// BEHAVIOUR
// - nrst low: async clear of all flops.
//   - ctr=0, tick=0, sq_wave=0, rst_out=0, state=PRE, hold_cnt=0, deb_cnt=0, manual_cnt=0, sync chain=0.
// - Divider: ctr is $clog2(TICK_DIV) bits wide.
//   - tick=1 in the cycle where ctr==TICK_DIV-1; ctr wraps to 0 on the next edge.
//   - First tick falls in cycle TICK_DIV-1 after nrst release.
//   - sq_wave toggles on each edge where tick=1.
// - Sync: each btn bit passes through SYNC_STAGES flops; combo_s = AND of the synced bits.
// - Debounce: if combo_s=0, deb_cnt clears to 0 on that edge.
//   - Otherwise deb_cnt increments on each tick, saturating at DEBOUNCE_TICKS.
//   - man_evt = (deb_cnt==DEBOUNCE_TICKS-1) & tick & combo_s.
// - FSM (registered; rst_out and state update on the same edge):
//   - PRE (rst_out=0): on tick -> HOLD, hold_cnt=0. Gives top a clean rising reset edge.
//   - HOLD (rst_out=1): hold_cnt increments on tick.
//     - On tick with hold_cnt==HOLD_TICKS-1 -> RUN.
//     - rst_out is high for exactly HOLD_TICKS*TICK_DIV cycles.
//   - RUN (rst_out=0): stays in RUN until man_evt.
//   - MANUAL (rst_out=1): stays while combo_s=1; on combo_s=0 -> PRE (no tick needed).
//   - man_evt in PRE, HOLD or RUN -> MANUAL at that edge; manual_cnt increments (saturating).
//   - man_evt has priority over any tick-driven PRE/HOLD transition in the same cycle.
// - In MANUAL, deb_cnt stays saturated; no new man_evt until combo_s drops and deb_cnt clears.
// - Combo released before debounce completes: deb_cnt clears, no reset, FSM unaffected.
// - nrst asserted mid-sequence: immediate return to the reset state above.
//   - rst_out drops to 0 asynchronously.
//   - The power-on sequence restarts from PRE after release.
// - rst_out is a flop output: glitch-free and synchronous to clk except during nrst assertion.
// - No combinational path from btn to any output.
// TESTING (TICK_DIV=4, HOLD_TICKS=3, DEBOUNCE_TICKS=2, NUM_BTN=3, SYNC_STAGES=2)
// - Release nrst with btn=0 -> tick in cycles 3,7,11,...
//   - rst_out rises after the cycle-3 edge and stays high 12 cycles.
//   - Then state=RUN, rst_out=0; sq_wave has period 8.
// - In RUN, hold btn=3'b111 -> after 2 sync cycles plus 2 ticks: rst_out=1, state=MANUAL, manual_cnt=1.
//   - Release -> PRE, then HOLD for 12 cycles, then RUN.
// - btn=3'b111 held for 1 tick then released, or btn=3'b011 held indefinitely -> no rst_out change, manual_cnt=0.
// - Combo held during the power-on HOLD -> MANUAL at the debounce tick.
//   - rst_out stays 1 across the transition with no 0 glitch.
// - Assert nrst mid-HOLD and mid-MANUAL -> all outputs return to their reset values immediately.
//   - After release, the full sequence repeats with identical cycle counts.
// - 256 debounced manual resets -> manual_cnt saturates at 255.

Source files
------------

// File: rtl/reset_tick_sequencer.sv
// ---------------------------------------------------------------------------
// reset_tick_sequencer
//
// Board-level reset and timebase block for the ice40 top level. The board
// clock is divided into a one-cycle tick pulse and a square wave (the 100 Hz
// timebase by default). That tick then sequences the design reset:
//   * a power-on hold: PRE -> HOLD for HOLD_TICKS ticks -> RUN
//   * a manual reset taken when all buttons of a combo are held for
//     DEBOUNCE_TICKS consecutive ticks. The reset stays asserted until the
//     combo is released, and then the power-on sequence is replayed.
//
// Ports
//   clk         design clock (hwclk)
//   nrst        asynchronous active-low reset, clears every flop
//   btn         raw asynchronous push buttons; the combo is the AND of all bits
//   tick        one-cycle pulse every TICK_DIV clocks
//   sq_wave     toggles on every tick (period 2*TICK_DIV)
//   rst_out     registered active-high reset driven into the rest of the design
//   state       sequencer state: 0=PRE 1=HOLD 2=RUN 3=MANUAL
//   manual_cnt  number of manual resets taken, saturating at 255
// ---------------------------------------------------------------------------
module reset_tick_sequencer #(
    parameter int TICK_DIV       = 100000,
    parameter int HOLD_TICKS     = 4,
    parameter int NUM_BTN        = 3,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_BTN-1:0] btn,
    output logic               tick,
    output logic               sq_wave,
    output logic               rst_out,
    output logic [1:0]         state,
    output logic [7:0]         manual_cnt
);

    // HOLD_TICKS == 1 would give a zero-width counter, so keep at least one bit.
    localparam int CTR_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [CTR_W-1:0]  CTR_LAST     = CTR_W'(TICK_DIV - 1);
    localparam logic [CTR_W-1:0]  CTR_PRE_LAST = CTR_W'(TICK_DIV - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX      = DEB_W'(DEBOUNCE_TICKS);
    localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_PRE    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_MANUAL = 2'd3
    } state_t;

    logic [CTR_W-1:0]   ctr;
    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic               combo_s;
    logic [DEB_W-1:0]   deb_cnt;
    logic               man_evt;
    state_t             cur_state;
    logic [HOLD_W-1:0]  hold_cnt;

    // Tick divider. The tick is registered: it is loaded one count early so
    // that it is high exactly while ctr sits at its last value. This keeps the
    // tick glitch-free for everything that consumes it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ctr     <= '0;
            tick    <= 1'b0;
            sq_wave <= 1'b0;
        end else begin
            if (ctr == CTR_LAST) begin
                ctr <= '0;
            end else begin
                ctr <= ctr + 1'b1;
            end
            tick <= (ctr == CTR_PRE_LAST);
            if (tick) begin
                sq_wave <= ~sq_wave;
            end
        end
    end

    // Each button bit passes through its own synchroniser chain before the
    // combo is formed. This means no button path reaches an output
    // combinationally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign combo_s = &sync_q[SYNC_STAGES-1];

    // Debounce counter. It counts ticks while the combo is held and clears as
    // soon as the combo drops. It saturates, so a held combo in MANUAL cannot
    // raise a second event.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            deb_cnt <= '0;
        end else if (!combo_s) begin
            deb_cnt <= '0;
        end else if (tick && (deb_cnt != DEB_MAX)) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign man_evt = tick & combo_s & (deb_cnt == DEB_LAST);

    // Reset sequencer. rst_out is updated on the same edge as the state, so
    // it is a clean flop output. A manual event is checked before any
    // tick-driven move, so it wins when both happen in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur_state  <= ST_PRE;
            hold_cnt   <= '0;
            rst_out    <= 1'b0;
            manual_cnt <= '0;
        end else begin
            case (cur_state)
                ST_PRE: begin
                    if (man_evt) begin
                        cur_state <= ST_MANUAL;
                        rst_out   <= 1'b1;
                        if (manual_cnt != 8'hFF) begin
                            manual_cnt <= manual_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        cur_state <= ST_HOLD;
                        hold_cnt  <= '0;
                        rst_out   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (man_evt) begin
                        cur_state <= ST_MANUAL;
                        rst_out   <= 1'b1;
                        if (manual_cnt != 8'hFF) begin
                            manual_cnt <= manual_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            cur_state <= ST_RUN;
                            rst_out   <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (man_evt) begin
                        cur_state <= ST_MANUAL;
                        rst_out   <= 1'b1;
                        if (manual_cnt != 8'hFF) begin
                            manual_cnt <= manual_cnt + 1'b1;
                        end
                    end
                end
                ST_MANUAL: begin
                    // Leaving MANUAL does not wait for a tick; PRE then
                    // provides the fresh rising reset edge.
                    if (!combo_s) begin
                        cur_state <= ST_PRE;
                        rst_out   <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= ST_PRE;
                    rst_out   <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule
